mem_arbiter: RTL

//  Shares the single cache port between the instruction-fetch (I) and data (D)

---
 rtl/mem_arbiter.sv | 85 ++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin I/D arbiter sequencing accesses onto one cache port with a completion watchdog
module mem_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_re,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_re,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_din,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  input  logic        mem_complete,
  output logic        busy,
  output logic        timeout_err
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state;
  logic last, gnt;
  logic [CNT_W-1:0] cnt;
  logic d_req, pick_d, cmpl, tmo;
  logic [31:0] rd_val;
  assign d_req = d_re | d_we;
  assign pick_d = d_req & (~i_re | ~last);
  assign cmpl = mem_complete & (cnt != '0);
  assign tmo = cnt == CNT_W'(TIMEOUT - 1);
  assign rd_val = cmpl ? mem_dout : 32'hDEAD_BEEF;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last <= 1'b0;
      gnt <= 1'b0;
      cnt <= '0;
      mem_addr <= '0;
      mem_din <= '0;
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_done <= 1'b0;
      d_done <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: if (i_re | d_req) begin
          gnt <= pick_d;
          last <= pick_d;
          cnt <= '0;
          mem_addr <= pick_d ? d_addr : i_addr;
          mem_din <= pick_d ? d_din : '0;
          mem_re <= pick_d ? (d_re & ~d_we) : 1'b1;
          mem_we <= pick_d & d_we;
          state <= BUSY;
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (cmpl | tmo) begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            d_done <= gnt;
            i_done <= ~gnt;
            if (mem_re & gnt) d_rdata <= rd_val;
            if (mem_re & ~gnt) i_rdata <= rd_val;
            if (!cmpl) timeout_err <= 1'b1;
            state <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
